// File: rtl/cla_pkg.sv
// Shared definitions for the CLA arithmetic units: divider FSM encoding and
// the fill value used for the quotient on a divide by zero.
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic DBZ_QUOTIENT_BIT = 1'b1;

endpackage

// File: rtl/cla_seq_divider_if.sv
// Start/busy/done handshake and operand/result bus of the sequential divider.
interface cla_seq_divider_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/cla_sub_nbit.sv
// Carry-lookahead subtractor: diff = a + ~b + 1. The final carry is the
// no-borrow flag (1 when a >= b).
module cla_sub_nbit #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         no_borrow
);
    logic [N-1:0] gen;
    logic [N-1:0] prop;
    logic [N:0]   carry;
    logic         run_p;
    logic         acc_c;

    assign gen  = a & ~b;
    assign prop = a ^ ~b;

    // Each carry is the flattened sum of generate terms gated by the propagate
    // run above them, ending with the carry-in of 1 propagated all the way.
    always_comb begin
        carry    = '0;
        carry[0] = 1'b1;
        run_p    = 1'b0;
        acc_c    = 1'b0;
        for (int i = 0; i < N; i++) begin
            acc_c = gen[i];
            run_p = prop[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc_c = acc_c | (run_p & gen[j]);
                run_p = run_p & prop[j];
            end
            carry[i+1] = acc_c | run_p;
        end
    end

    assign diff      = prop ^ carry[N-1:0];
    assign no_borrow = carry[N];
endmodule

// File: rtl/cla_seq_divider.sv
// Multi-cycle unsigned restoring divider; one CLA trial subtraction per clock,
// with a start/busy/done handshake.
module cla_seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    cla_seq_divider_if.slave  bus
);
    import cla_pkg::*;

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    state_t           next_state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] res_quo;
    logic [WIDTH-1:0] res_rem;
    logic             res_dbz;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             no_borrow;
    logic [WIDTH-1:0] next_rem;
    logic [WIDTH-1:0] next_quo;
    logic             accept;
    logic             last_iter;
    logic             zero_div;
    logic             unused_diff_msb;

    // Partial remainder keeps its MSB: the trial value is WIDTH+1 bits wide.
    assign trial = {rem, quo[WIDTH-1]};

    cla_sub_nbit #(.N(WIDTH + 1)) u_sub (
        .a         (trial),
        .b         ({1'b0, dvs}),
        .diff      (diff),
        .no_borrow (no_borrow)
    );

    assign unused_diff_msb = diff[WIDTH];
    assign next_rem        = no_borrow ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    assign next_quo        = {quo[WIDTH-2:0], no_borrow};
    assign zero_div        = (bus.divisor == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        last_iter  = 1'b0;
        bus.busy   = (state == RUN);
        bus.done   = (state == DONE);
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    next_state = zero_div ? DONE : RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            RUN: begin
                if (count == CW'(1)) begin
                    last_iter  = 1'b1;
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Published results only change on entry to DONE; the shift registers
    // are private working state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            res_quo <= '0;
            res_rem <= '0;
            res_dbz <= 1'b0;
        end else if (accept) begin
            dvs     <= bus.divisor;
            res_dbz <= zero_div;
            if (zero_div) begin
                res_quo <= {WIDTH{DBZ_QUOTIENT_BIT}};
                res_rem <= bus.dividend;
            end else begin
                rem   <= '0;
                quo   <= bus.dividend;
                count <= CW'(WIDTH);
            end
        end else if (state == RUN) begin
            rem   <= next_rem;
            quo   <= next_quo;
            count <= count - CW'(1);
            if (last_iter) begin
                res_quo <= next_quo;
                res_rem <= next_rem;
            end
        end
    end

    assign bus.quotient    = res_quo;
    assign bus.remainder   = res_rem;
    assign bus.div_by_zero = res_dbz;
endmodule

// File: tb/tb_cla_seq_divider.sv
// Bench for cla_seq_divider (WIDTH=4): directed vectors plus a latency-level
// reference model using / and % checked every cycle.
module tb_cla_seq_divider;
    localparam int WIDTH = 4;

    logic clk;
    logic rst;

    cla_seq_divider_if #(.WIDTH(WIDTH)) bus ();

    cla_seq_divider #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests       = 0;
    int failed      = 0;
    int done_pulses = 0;

    logic             m_busy;
    logic             m_done;
    int               m_left;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] m_r;
    logic             m_z;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] p_r;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: an accepted request produces done WIDTH edges later (or on the
    // very next cycle for a zero divisor) with quotient/remainder from / and %.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
            m_q    <= '0;
            m_r    <= '0;
            m_z    <= 1'b0;
            p_q    <= '0;
            p_r    <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_q    <= p_q;
                    m_r    <= p_r;
                end
                m_left <= m_left - 1;
            end else if (bus.start) begin
                m_z <= (bus.divisor == 0);
                if (bus.divisor == 0) begin
                    m_done <= 1'b1;
                    m_q    <= '1;
                    m_r    <= bus.dividend;
                end else begin
                    m_busy <= 1'b1;
                    m_left <= WIDTH;
                    p_q    <= bus.dividend / bus.divisor;
                    p_r    <= bus.dividend % bus.divisor;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("busy", bus.busy, m_busy);
            checkOutput("done", bus.done, m_done);
            checkOutput("quotient", bus.quotient, m_q);
            checkOutput("remainder", bus.remainder, m_r);
            checkOutput("div_by_zero", bus.div_by_zero, m_z);
            if (bus.done) done_pulses++;
        end
    end

    // Called at a negedge with the divider idle or in DONE; returns at the
    // negedge where done is seen (or after a bounded wait).
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                                 output int edges, output int busy_cycles);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start   = 1'b0;
        edges       = 0;
        busy_cycles = 0;
        while (bus.done !== 1'b1 && edges < 20) begin
            if (bus.busy) busy_cycles++;
            @(negedge clk);
            edges++;
        end
    endtask

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int z;
    } vec_t;

    vec_t vecs [6] = '{
        '{13, 3,  4, 1, 0},
        '{ 7, 0, 15, 7, 1},
        '{15, 1, 15, 0, 0},
        '{ 2, 9,  0, 2, 0},
        '{15, 15, 1, 0, 0},
        '{ 0, 5,  0, 0, 0}
    };

    initial begin
        int edges;
        int busy_cycles;
        int pulses0;
        int n;

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #12;
        checkOutput("reset busy", bus.busy, 0);
        checkOutput("reset done", bus.done, 0);
        checkOutput("reset quotient", bus.quotient, 0);
        checkOutput("reset remainder", bus.remainder, 0);
        checkOutput("reset div_by_zero", bus.div_by_zero, 0);
        @(negedge clk);
        #3 rst = 1'b0;
        @(negedge clk);

        // Directed vectors with literal expectations and latency
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].a[3:0], vecs[i].b[3:0], edges, busy_cycles);
            checkOutput($sformatf("vec%0d quotient", i), bus.quotient, vecs[i].q);
            checkOutput($sformatf("vec%0d remainder", i), bus.remainder, vecs[i].r);
            checkOutput($sformatf("vec%0d div_by_zero", i), bus.div_by_zero, vecs[i].z);
            checkOutput($sformatf("vec%0d edges incl accept", i), edges + 1, (vecs[i].z != 0) ? 1 : 5);
            checkOutput($sformatf("vec%0d busy cycles", i), busy_cycles, (vecs[i].z != 0) ? 0 : 4);
        end

        // Start pulsed while busy must be ignored
        bus.dividend = 4'd12;
        bus.divisor  = 4'd5;
        bus.start    = 1'b1;
        @(posedge clk);
        #1 pulses0 = done_pulses;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        checkOutput("ignored-start busy", bus.busy, 1);
        bus.dividend = 4'd9;
        bus.divisor  = 4'd2;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ignored-start quotient", bus.quotient, 2);
        checkOutput("ignored-start remainder", bus.remainder, 2);
        repeat (8) @(negedge clk);
        #1 checkOutput("ignored-start done pulses", done_pulses - pulses0, 1);

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        bus.dividend = 4'd11;
        bus.divisor  = 4'd3;
        bus.start    = 1'b1;
        @(posedge clk);
        #1 pulses0 = done_pulses;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort busy", bus.busy, 0);
        checkOutput("abort done", bus.done, 0);
        checkOutput("abort quotient", bus.quotient, 0);
        checkOutput("abort remainder", bus.remainder, 0);
        checkOutput("abort div_by_zero", bus.div_by_zero, 0);
        @(negedge clk);
        #3 rst = 1'b0;
        repeat (6) @(negedge clk);
        #1 checkOutput("abort done pulses", done_pulses - pulses0, 0);
        @(negedge clk);
        applyStimulus(4'd6, 4'd4, edges, busy_cycles);
        checkOutput("after-abort quotient", bus.quotient, 1);
        checkOutput("after-abort remainder", bus.remainder, 2);

        // Back-to-back: start held high through DONE
        @(negedge clk);
        bus.dividend = 4'd13;
        bus.divisor  = 4'd3;
        bus.start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("b2b first quotient", bus.quotient, 4);
        checkOutput("b2b first remainder", bus.remainder, 1);
        bus.dividend = 4'd14;
        bus.divisor  = 4'd4;
        @(negedge clk);
        checkOutput("b2b no idle busy", bus.busy, 1);
        bus.start = 1'b0;
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("b2b second quotient", bus.quotient, 3);
        checkOutput("b2b second remainder", bus.remainder, 2);

        // Exhaustive sweep against / and %
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                applyStimulus(a[3:0], b[3:0], edges, busy_cycles);
                checkOutput($sformatf("sweep %0d/%0d quotient", a, b), bus.quotient, (b == 0) ? 15 : a / b);
                checkOutput($sformatf("sweep %0d/%0d remainder", a, b), bus.remainder, (b == 0) ? a : a % b);
                checkOutput($sformatf("sweep %0d/%0d div_by_zero", a, b), bus.div_by_zero, (b == 0) ? 1 : 0);
            end
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
